// File: rtl/fp_16_to_32_convert_stream.sv
// rtl/fp_16_to_32_convert_stream.sv - multi-lane pipelined FP16/BF16 to FP32 widening converter
//
// Purpose: converts LANES 16-bit operands per beat (FP16 or BF16, chosen
// per beat by mode_i) to FP32 behind a valid/ready stream interface.
// Conversion is combinational ahead of the first register; later stages
// only delay. Each stage advances when it is empty or everything
// downstream of it can move, so bubbles compress.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   valid_i/ready_o input beat handshake (ready_o combinational from ready_i)
//   mode_i          0 = FP16, 1 = BF16, applies to all lanes of the beat
//   operand_i       LANES x 16-bit operands, lane k at [16k+15:16k]
//   valid_o/ready_i output beat handshake
//   result_o        LANES x FP32 results, lane k at [32k+31:32k]
//   subnormal_o     per lane: input was a nonzero FP16 subnormal
//   nan_o           per lane: input was NaN
//   beat_count_o    accepted input beats, wrapping
module fp_16_to_32_convert_stream #(
  parameter int LANES         = 4,
  parameter int PIPE_STAGES   = 2,
  parameter bit NAN_CANONICAL = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  mode_i,
  input  logic [LANES*16-1:0]   operand_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [LANES*32-1:0]   result_o,
  output logic [LANES-1:0]      subnormal_o,
  output logic [LANES-1:0]      nan_o,
  output logic [31:0]           beat_count_o
);

  localparam int LAST = PIPE_STAGES - 1;

  // Returns {subnormal, nan, fp32} for one lane.
  function automatic logic [33:0] convert(input logic [15:0] x, input logic bf);
    logic        s;
    logic [4:0]  e;
    logic [9:0]  m;
    logic [3:0]  p;
    logic [19:0] sh;
    logic [31:0] res;
    logic        sub;
    logic        nan;
    s   = x[15];
    e   = x[14:10];
    m   = x[9:0];
    p   = 4'd0;
    sh  = 20'd0;
    res = 32'd0;
    sub = 1'b0;
    nan = 1'b0;
    if (bf) begin
      res = {x, 16'h0000};
      if (x[14:7] == 8'hFF && x[6:0] != 7'd0) begin
        nan = 1'b1;
        res = NAN_CANONICAL ? 32'h7FC0_0000 : (res | 32'h0040_0000);
      end
    end else if (e == 5'd0) begin
      if (m == 10'd0) begin
        res = {s, 31'd0};
      end else begin
        // Leading-one position sets the exponent; shifting it out of the
        // 10-bit field leaves the normalised fraction.
        for (int i = 0; i < 10; i++) begin
          if (m[i]) p = 4'(i);
        end
        sh  = {10'd0, m} << (4'd10 - p);
        res = {s, {4'd0, p} + 8'd103, sh[9:0], 13'h0000};
        sub = 1'b1;
      end
    end else if (e == 5'h1F) begin
      if (m == 10'd0) begin
        res = {s, 8'hFF, 23'd0};
      end else begin
        nan = 1'b1;
        res = NAN_CANONICAL ? 32'h7FC0_0000 : {s, 8'hFF, 1'b1, m[8:0], 13'h0000};
      end
    end else begin
      res = {s, {3'd0, e} + 8'd112, m, 13'h0000};
    end
    return {sub, nan, res};
  endfunction

  logic [PIPE_STAGES-1:0] vld_q;
  logic [PIPE_STAGES-1:0] adv;
  logic [LANES*32-1:0]    res_q [PIPE_STAGES];
  logic [LANES-1:0]       sub_q [PIPE_STAGES];
  logic [LANES-1:0]       nan_q [PIPE_STAGES];
  logic [31:0]            beat_cnt_q;

  logic [LANES*32-1:0]    cvt_res;
  logic [LANES-1:0]       cvt_sub;
  logic [LANES-1:0]       cvt_nan;

  always_comb begin
    logic [33:0] r;
    cvt_res = '0;
    cvt_sub = '0;
    cvt_nan = '0;
    r       = '0;
    for (int k = 0; k < LANES; k++) begin
      r                  = convert(operand_i[16*k +: 16], mode_i);
      cvt_res[32*k +: 32] = r[31:0];
      cvt_nan[k]          = r[32];
      cvt_sub[k]          = r[33];
    end
  end

  // Stage s advances unless ready_i is low and stages s..LAST are all full.
  // Built as a running AND from the output end so there is no
  // self-referencing chain on adv.
  always_comb begin
    logic all_full;
    all_full = 1'b1;
    adv      = '0;
    for (int s = LAST; s >= 0; s--) begin
      all_full = all_full & vld_q[s];
      adv[s]   = ready_i | ~all_full;
    end
  end

  assign ready_o      = adv[0];
  assign valid_o      = vld_q[LAST];
  assign result_o     = res_q[LAST];
  assign subnormal_o  = sub_q[LAST];
  assign nan_o        = nan_q[LAST];
  assign beat_count_o = beat_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q      <= '0;
      beat_cnt_q <= '0;
      for (int s = 0; s < PIPE_STAGES; s++) begin
        res_q[s] <= '0;
        sub_q[s] <= '0;
        nan_q[s] <= '0;
      end
    end else begin
      if (valid_i && adv[0]) begin
        beat_cnt_q <= beat_cnt_q + 32'd1;
      end
      if (adv[0]) begin
        vld_q[0] <= valid_i;
        // Payload only moves with a real beat; bubbles leave it untouched.
        if (valid_i) begin
          res_q[0] <= cvt_res;
          sub_q[0] <= cvt_sub;
          nan_q[0] <= cvt_nan;
        end
      end
      for (int s = 1; s < PIPE_STAGES; s++) begin
        if (adv[s]) begin
          vld_q[s] <= vld_q[s-1];
          if (vld_q[s-1]) begin
            res_q[s] <= res_q[s-1];
            sub_q[s] <= sub_q[s-1];
            nan_q[s] <= nan_q[s-1];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_16_to_32_convert_stream.sv
// tb/tb_fp_16_to_32_convert_stream.sv - directed self-checking bench for fp_16_to_32_convert_stream
module tb_fp_16_to_32_convert_stream;

  localparam int LANES = 4;
  localparam int PS    = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid_i = 1'b0;
  logic         mode = 1'b0;
  logic         ready_i = 1'b1;
  logic [63:0]  operand = '0;

  logic         ready_a, valid_a, ready_b, valid_b;
  logic [127:0] res_a, res_b;
  logic [3:0]   sub_a, nan_a, sub_b, nan_b;
  logic [31:0]  cnt_a, cnt_b;

  int total = 0;
  int bad   = 0;

  fp_16_to_32_convert_stream #(.LANES(LANES), .PIPE_STAGES(PS), .NAN_CANONICAL(1'b1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_a), .mode_i(mode),
    .operand_i(operand), .valid_o(valid_a), .ready_i(ready_i), .result_o(res_a),
    .subnormal_o(sub_a), .nan_o(nan_a), .beat_count_o(cnt_a)
  );

  fp_16_to_32_convert_stream #(.LANES(LANES), .PIPE_STAGES(PS), .NAN_CANONICAL(1'b0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_b), .mode_i(mode),
    .operand_i(operand), .valid_o(valid_b), .ready_i(ready_i), .result_o(res_b),
    .subnormal_o(sub_b), .nan_o(nan_b), .beat_count_o(cnt_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One isolated beat through both instances, ready_i held high.
  task automatic do_beat(input string tag, input logic md, input logic [63:0] op,
                         input logic [127:0] exp_a, input logic [127:0] exp_b,
                         input logic [3:0] exp_sub, input logic [3:0] exp_nan);
    @(negedge clk);
    valid_i = 1'b1;
    mode    = md;
    operand = op;
    #1;
    chk({tag, "_ready"}, 128'(ready_a), 128'(1'b1));
    @(negedge clk);
    valid_i = 1'b0;
    for (int i = 1; i < PS; i++) begin
      chk({tag, "_early"}, 128'(valid_a), 128'(1'b0));
      @(negedge clk);
    end
    chk({tag, "_valid"}, 128'(valid_a), 128'(1'b1));
    chk({tag, "_res"}, res_a, exp_a);
    chk({tag, "_res_nc"}, res_b, exp_b);
    chk({tag, "_sub"}, 128'(sub_a), 128'(exp_sub));
    chk({tag, "_nan"}, 128'(nan_a), 128'(exp_nan));
    chk({tag, "_nan_nc"}, 128'(nan_b), 128'(exp_nan));
  endtask

  // FP16 normals with exponent 15 map to exponent 127 with the fraction
  // shifted up by 13.
  function automatic logic [63:0] bp_op(input int i);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < 4; k++) v[16*k +: 16] = {1'b0, 5'd15, 10'(i * 4 + k + 1)};
    return v;
  endfunction

  function automatic logic [127:0] bp_exp(input int i);
    logic [127:0] v;
    v = '0;
    for (int k = 0; k < 4; k++) v[32*k +: 32] = {1'b0, 8'd127, 10'(i * 4 + k + 1), 13'h0};
    return v;
  endfunction

  initial begin
    int          sent, recv, occ;
    logic        saw_drop, prev_stall;
    logic [127:0] prev_res;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 128'(valid_a), 128'(1'b0));
    chk("rst_result", res_a, 128'(0));
    chk("rst_flags", 128'({sub_a, nan_a}), 128'(0));
    chk("rst_count", 128'(cnt_a), 128'(0));
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 128'(ready_a), 128'(1'b1));

    do_beat("fp16_norm", 1'b0, {16'h8000, 16'h0000, 16'hC000, 16'h3C00},
            {32'h8000_0000, 32'h0000_0000, 32'hC000_0000, 32'h3F80_0000},
            {32'h8000_0000, 32'h0000_0000, 32'hC000_0000, 32'h3F80_0000},
            4'b0000, 4'b0000);
    do_beat("fp16_sub", 1'b0, {16'h0010, 16'h8200, 16'h03FF, 16'h0001},
            {32'h3580_0000, 32'hB800_0000, 32'h387F_C000, 32'h3380_0000},
            {32'h3580_0000, 32'hB800_0000, 32'h387F_C000, 32'h3380_0000},
            4'b1111, 4'b0000);
    do_beat("fp16_spec", 1'b0, {16'hFD00, 16'h7E01, 16'hFC00, 16'h7C00},
            {32'h7FC0_0000, 32'h7FC0_0000, 32'hFF80_0000, 32'h7F80_0000},
            {32'hFFE0_0000, 32'h7FC0_2000, 32'hFF80_0000, 32'h7F80_0000},
            4'b0000, 4'b1100);
    do_beat("bf16", 1'b1, {16'hFF80, 16'h7F81, 16'h0001, 16'h4049},
            {32'hFF80_0000, 32'h7FC0_0000, 32'h0001_0000, 32'h4049_0000},
            {32'hFF80_0000, 32'h7FC1_0000, 32'h0001_0000, 32'h4049_0000},
            4'b0000, 4'b0100);
    chk("count_4", 128'(cnt_a), 128'(32'd4));

    // Backpressure: fresh counter, 10 beats, ready_i low for cycles 3..8.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sent = 0;
    recv = 0;
    saw_drop = 1'b0;
    prev_stall = 1'b0;
    prev_res = '0;
    for (int c = 0; c < 60 && recv < 10; c++) begin
      @(negedge clk);
      ready_i = !(c >= 3 && c <= 8);
      valid_i = (sent < 10);
      mode    = 1'b0;
      operand = bp_op(sent);
      #1;
      if (prev_stall) begin
        chk("bp_hold_valid", 128'(valid_a), 128'(1'b1));
        chk("bp_hold_data", res_a, prev_res);
      end
      occ = sent - recv;
      chk("bp_ready", 128'(ready_a), 128'(ready_i || (occ < PS)));
      if (!ready_a) saw_drop = 1'b1;
      if (valid_a && ready_i) begin
        chk("bp_data", res_a, bp_exp(recv));
        recv++;
      end
      if (valid_i && ready_a) sent++;
      prev_stall = valid_a && !ready_i;
      prev_res   = res_a;
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    chk("bp_recv", 128'(recv), 128'(10));
    chk("bp_sent", 128'(sent), 128'(10));
    chk("bp_drop_seen", 128'(saw_drop), 128'(1'b1));
    @(negedge clk);
    chk("bp_no_dup", 128'(valid_a), 128'(1'b0));
    chk("bp_count", 128'(cnt_a), 128'(32'd10));

    // Reset with two beats in flight.
    @(negedge clk);
    valid_i = 1'b1;
    operand = {16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00};
    @(negedge clk);
    operand = {16'h4000, 16'h4000, 16'h4000, 16'h4000};
    @(negedge clk);
    valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(valid_a), 128'(1'b0));
    chk("mid_rst_count", 128'(cnt_a), 128'(0));
    @(negedge clk);
    rst_n   = 1'b1;
    valid_i = 1'b1;
    operand = {16'hC400, 16'hC400, 16'hC400, 16'hC400};
    #1;
    chk("post_rst_ready", 128'(ready_a), 128'(1'b1));
    @(negedge clk);
    valid_i = 1'b0;
    for (int i = 1; i < PS; i++) begin
      chk("post_rst_early", 128'(valid_a), 128'(1'b0));
      @(negedge clk);
    end
    chk("post_rst_valid", 128'(valid_a), 128'(1'b1));
    chk("post_rst_res", res_a, {32'hC080_0000, 32'hC080_0000, 32'hC080_0000, 32'hC080_0000});
    @(negedge clk);
    chk("post_rst_alone", 128'(valid_a), 128'(1'b0));
    chk("post_rst_count", 128'(cnt_a), 128'(32'd1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
